// File: rtl/execute_stage_mc_if.sv
// Decode-to-execute op bundle and execute-to-memory result bundle.
// master: drives op fields, hold/flush; slave: the execute stage.
interface execute_stage_mc_if #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int ADDR_W   = 5,
    parameter int ALU_OP_W = 3,
    parameter int NUM_BYP  = 2,
    parameter int CTRL_W   = 6,
    parameter int SEL_W    = $clog2(NUM_BYP + 1)
);
    logic                      in_valid_i;
    logic                      in_ready_o;
    logic                      hold_i;
    logic                      flush_i;
    logic [ALU_OP_W-1:0]       alu_op_i;
    logic                      alu_alt_i;
    logic                      has_imm_i;
    logic                      jump_i;
    logic                      muldiv_i;
    logic [1:0]                md_op_i;
    logic [CTRL_W-1:0]         ctrl_i;
    logic [DATA_W-1:0]         imm32_i;
    logic [PC_W-1:0]           pc_plus1_i;
    logic [DATA_W-1:0]         rf_data0_i;
    logic [DATA_W-1:0]         rf_data1_i;
    logic [ADDR_W-1:0]         rf_waddr_i;
    logic [NUM_BYP*DATA_W-1:0] byp_data_i;
    logic [SEL_W-1:0]          src0_sel_i;
    logic [SEL_W-1:0]          src1_sel_i;
    logic                      valid_o;
    logic [CTRL_W-1:0]         ctrl_o;
    logic [ADDR_W-1:0]         rf_waddr_o;
    logic [DATA_W-1:0]         result_o;
    logic [DATA_W-1:0]         mem_wdata_o;
    logic [PC_W-1:0]           pc_branch_o;
    logic                      busy_o;
    logic [ADDR_W-1:0]         rf_dst_o;

    modport master (
        output in_valid_i, hold_i, flush_i, alu_op_i, alu_alt_i,
        output has_imm_i, jump_i, muldiv_i, md_op_i, ctrl_i,
        output imm32_i, pc_plus1_i, rf_data0_i, rf_data1_i,
        output rf_waddr_i, byp_data_i, src0_sel_i, src1_sel_i,
        input  in_ready_o, valid_o, ctrl_o, rf_waddr_o, result_o,
        input  mem_wdata_o, pc_branch_o, busy_o, rf_dst_o
    );

    modport slave (
        input  in_valid_i, hold_i, flush_i, alu_op_i, alu_alt_i,
        input  has_imm_i, jump_i, muldiv_i, md_op_i, ctrl_i,
        input  imm32_i, pc_plus1_i, rf_data0_i, rf_data1_i,
        input  rf_waddr_i, byp_data_i, src0_sel_i, src1_sel_i,
        output in_ready_o, valid_o, ctrl_o, rf_waddr_o, result_o,
        output mem_wdata_o, pc_branch_o, busy_o, rf_dst_o
    );
endinterface

// File: rtl/execute_stage_mc.sv
// Execute stage: NUM_BYP-way operand bypass, single-cycle ALU, and an
// optional iterative mul/div unit (macro EXEC_MULDIV_EN).
// Ports: clk, reset (async, active-low), bus (execute_stage_mc_if.slave).
// Without EXEC_MULDIV_EN, muldiv ops retire in one cycle with result 0.
module execute_stage_mc #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int ADDR_W   = 5,
    parameter int ALU_OP_W = 3,
    parameter int NUM_BYP  = 2,
    parameter int CTRL_W   = 6,
    parameter int SEL_W    = $clog2(NUM_BYP + 1)
) (
    input logic               clk,
    input logic               reset,
    execute_stage_mc_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] w_src0;
    logic [DATA_W-1:0] w_fwd1;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_sc_res;
    logic [SH_W-1:0]   w_shamt;
    logic [PC_W-1:0]   w_pc_ret;
    logic [PC_W-1:0]   w_pcb;
    logic              w_ready;
    logic              w_accept;
    logic              w_go_busy;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_wdata;
    logic [PC_W-1:0]   r_pcb;

    // Code 0 picks RF, code k picks bypass slice k-1, anything above is 0.
    function automatic logic [DATA_W-1:0] f_sel(
        input logic [SEL_W-1:0]          sel,
        input logic [DATA_W-1:0]         rf,
        input logic [NUM_BYP*DATA_W-1:0] byp
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (sel == '0) v = rf;
        for (int k = 1; k <= NUM_BYP; k++) begin
            if (sel == SEL_W'(k)) v = byp[(k-1)*DATA_W +: DATA_W];
        end
        return v;
    endfunction

    always_comb begin
        w_src0 = f_sel(bus.src0_sel_i, bus.rf_data0_i, bus.byp_data_i);
        w_fwd1 = f_sel(bus.src1_sel_i, bus.rf_data1_i, bus.byp_data_i);
        w_src1 = bus.has_imm_i ? bus.imm32_i : w_fwd1;
    end

    assign w_shamt = w_src1[SH_W-1:0];

    always_comb begin
        w_alu = '0;
        case (bus.alu_op_i)
            ALU_OP_W'(0): begin
                if (bus.alu_alt_i) w_alu = w_src0 - w_src1;
                else               w_alu = w_src0 + w_src1;
            end
            ALU_OP_W'(1): w_alu = w_src0 << w_shamt;
            ALU_OP_W'(2): w_alu = {{(DATA_W-1){1'b0}},
                                   ($signed(w_src0) < $signed(w_src1))};
            ALU_OP_W'(3): w_alu = {{(DATA_W-1){1'b0}}, (w_src0 < w_src1)};
            ALU_OP_W'(4): w_alu = w_src0 ^ w_src1;
            ALU_OP_W'(5): begin
                if (bus.alu_alt_i)
                    w_alu = DATA_W'($signed(w_src0) >>> w_shamt);
                else
                    w_alu = w_src0 >> w_shamt;
            end
            ALU_OP_W'(6): w_alu = w_src0 | w_src1;
            default:      w_alu = w_src0 & w_src1;
        endcase
    end

    assign w_pc_ret = bus.pc_plus1_i + PC_W'(1);
    assign w_pcb    = (bus.has_imm_i && bus.jump_i) ? PC_W'(w_alu)
                    : bus.pc_plus1_i + PC_W'(bus.imm32_i);

`ifdef EXEC_MULDIV_EN
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_md_op;
    logic [DATA_W-1:0]   r_dvsr;
    logic [2*DATA_W-1:0] r_acc;
    logic [CTRL_W-1:0]   r_md_ctrl;
    logic [ADDR_W-1:0]   r_md_waddr;
    logic [DATA_W-1:0]   r_md_wdata;
    logic [PC_W-1:0]     r_md_pcb;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_trial;
    logic [2*DATA_W-1:0] w_acc_nxt;
    logic [DATA_W-1:0]   w_md_res;

    // r_acc = {high, low}. Multiply: low starts as multiplier, partial
    // sums enter high and everything shifts right. Divide: low starts as
    // dividend, high is the running remainder; quotient bits shift into
    // low. A zero divisor never borrows, giving all-ones quotient and the
    // dividend as remainder without special casing.
    always_comb begin
        w_sum = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
              + (r_acc[0] ? {1'b0, r_dvsr} : '0);
        w_trial = r_acc[2*DATA_W-1:DATA_W-1] - {1'b0, r_dvsr};
        w_acc_nxt = {r_acc[2*DATA_W-2:0], 1'b0};
        if (!r_md_op[1])
            w_acc_nxt = {w_sum, r_acc[DATA_W-1:1]};
        else if (!w_trial[DATA_W])
            w_acc_nxt = {w_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
    end

    always_comb begin
        w_md_res = w_acc_nxt[DATA_W-1:0];
        if (r_md_op[0]) w_md_res = w_acc_nxt[2*DATA_W-1:DATA_W];
    end

    assign w_ready   = (r_state == S_IDLE) && !bus.hold_i;
    assign w_go_busy = bus.muldiv_i;
    assign w_sc_res  = bus.jump_i ? DATA_W'(w_pc_ret) : w_alu;
    assign bus.busy_o = (r_state == S_BUSY);
`else
    logic w_unused_md;

    assign w_unused_md = ^bus.md_op_i;
    assign w_ready     = !bus.hold_i;
    assign w_go_busy   = 1'b0;
    assign w_sc_res    = bus.muldiv_i ? '0
                       : bus.jump_i ? DATA_W'(w_pc_ret) : w_alu;
    assign bus.busy_o  = 1'b0;
`endif

    assign w_accept = bus.in_valid_i && w_ready && !bus.flush_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_waddr    <= '0;
            r_result   <= '0;
            r_wdata    <= '0;
            r_pcb      <= '0;
`ifdef EXEC_MULDIV_EN
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_md_op    <= '0;
            r_dvsr     <= '0;
            r_acc      <= '0;
            r_md_ctrl  <= '0;
            r_md_waddr <= '0;
            r_md_wdata <= '0;
            r_md_pcb   <= '0;
`endif
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
`ifdef EXEC_MULDIV_EN
            r_state <= S_IDLE;
`endif
        end else if (!bus.hold_i) begin
            r_valid <= 1'b0;
            if (w_accept && !w_go_busy) begin
                r_valid  <= 1'b1;
                r_ctrl   <= bus.ctrl_i;
                r_waddr  <= bus.rf_waddr_i;
                r_result <= w_sc_res;
                r_wdata  <= w_fwd1;
                r_pcb    <= w_pcb;
            end
`ifdef EXEC_MULDIV_EN
            if (w_accept && w_go_busy) begin
                r_state    <= S_BUSY;
                r_cnt      <= CNT_W'(DATA_W - 1);
                r_md_op    <= bus.md_op_i;
                r_dvsr     <= w_src1;
                r_acc      <= {{DATA_W{1'b0}}, w_src0};
                r_md_ctrl  <= bus.ctrl_i;
                r_md_waddr <= bus.rf_waddr_i;
                r_md_wdata <= w_fwd1;
                r_md_pcb   <= w_pcb;
            end
            if (r_state == S_BUSY) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    r_state  <= S_IDLE;
                    r_valid  <= 1'b1;
                    r_ctrl   <= r_md_ctrl;
                    r_waddr  <= r_md_waddr;
                    r_result <= w_md_res;
                    r_wdata  <= r_md_wdata;
                    r_pcb    <= r_md_pcb;
                end
            end
`endif
        end
    end

    assign bus.in_ready_o  = w_ready;
    assign bus.valid_o     = r_valid;
    assign bus.ctrl_o      = r_ctrl;
    assign bus.rf_waddr_o  = r_waddr;
    assign bus.result_o    = r_result;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.pc_branch_o = r_pcb;
    assign bus.rf_dst_o    = bus.rf_waddr_i;
endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed plus randomized bench for execute_stage_mc.
// Expectations adapt to whether EXEC_MULDIV_EN is defined.
module tb_execute_stage_mc;
    localparam int DW = 32;

`ifdef EXEC_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    execute_stage_mc_if #(
        .DATA_W(32), .PC_W(32), .ADDR_W(5), .ALU_OP_W(3),
        .NUM_BYP(2), .CTRL_W(6)
    ) bus ();

    execute_stage_mc #(
        .DATA_W(32), .PC_W(32), .ADDR_W(5), .ALU_OP_W(3),
        .NUM_BYP(2), .CTRL_W(6)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.in_valid_i = 0; bus.hold_i = 0; bus.flush_i = 0;
        bus.alu_op_i = 0; bus.alu_alt_i = 0; bus.has_imm_i = 0;
        bus.jump_i = 0; bus.muldiv_i = 0; bus.md_op_i = 0;
        bus.ctrl_i = 0; bus.imm32_i = 0; bus.pc_plus1_i = 0;
        bus.rf_data0_i = 0; bus.rf_data1_i = 0; bus.rf_waddr_i = 0;
        bus.byp_data_i = 0; bus.src0_sel_i = 0; bus.src1_sel_i = 0;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel,
                                         input logic [31:0] rf,
                                         input logic [63:0] byp);
        case (sel)
            2'd0:    return rf;
            2'd1:    return byp[31:0];
            2'd2:    return byp[63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input int op, input bit alt,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            0: return alt ? a - b : a + b;
            1: return a << b[4:0];
            2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3: return (a < b) ? 32'd1 : 32'd0;
            4: return a ^ b;
            5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [31:0] m_md(input logic [1:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic model_sc(output logic [31:0] res,
                            output logic [31:0] pcb,
                            output logic [31:0] wd);
        logic [31:0] a, f1, b, alu;
        a   = pick(bus.src0_sel_i, bus.rf_data0_i, bus.byp_data_i);
        f1  = pick(bus.src1_sel_i, bus.rf_data1_i, bus.byp_data_i);
        b   = bus.has_imm_i ? bus.imm32_i : f1;
        alu = m_alu(int'(bus.alu_op_i), bus.alu_alt_i, a, b);
        if (bus.muldiv_i)    res = 32'd0;
        else if (bus.jump_i) res = bus.pc_plus1_i + 32'd1;
        else                 res = alu;
        pcb = (bus.has_imm_i && bus.jump_i) ? alu
            : bus.pc_plus1_i + bus.imm32_i;
        wd  = f1;
    endtask

    task automatic sc_check(input string tag);
        logic [31:0] er, ep, ew;
        logic [5:0]  ec;
        logic [4:0]  ea;
        model_sc(er, ep, ew);
        ec = bus.ctrl_i;
        ea = bus.rf_waddr_i;
        step();
        chk({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        chk({tag, "_res"}, bus.result_o, er);
        chk({tag, "_pcb"}, bus.pc_branch_o, ep);
        chk({tag, "_wd"}, bus.mem_wdata_o, ew);
        chk({tag, "_meta"}, {bus.ctrl_o, bus.rf_waddr_o}, {ec, ea});
    endtask

    task automatic run_md(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int hold_at, input int hold_len);
        logic [31:0] exp;
        logic [5:0]  ec;
        logic [4:0]  ea;
        int          lat;
        int          exp_lat;
        bit          busy_ok;
        clr();
        bus.in_valid_i = 1; bus.muldiv_i = 1; bus.md_op_i = op;
        bus.rf_data0_i = a; bus.rf_data1_i = b;
        bus.ctrl_i = 6'($urandom); bus.rf_waddr_i = 5'($urandom);
        ec = bus.ctrl_i;
        ea = bus.rf_waddr_i;
        step();
        bus.in_valid_i = 0; bus.muldiv_i = 0;
        lat = 1;
        busy_ok = 1;
        while (bus.valid_o !== 1'b1 && lat < 200) begin
            if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b0)
                busy_ok = 0;
            bus.hold_i = (lat >= hold_at && lat < hold_at + hold_len);
            step();
            lat++;
        end
        bus.hold_i = 0;
        exp     = MD_EN ? m_md(op, a, b) : 32'd0;
        exp_lat = MD_EN ? DW + 1 + hold_len : 1;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, bus.result_o, exp);
        chk({tag, "_busywin"}, 32'(busy_ok), 32'd1);
        chk({tag, "_meta"}, {bus.ctrl_o, bus.rf_waddr_o}, {ec, ea});
        step();
        chk({tag, "_done"}, {bus.valid_o, bus.busy_o}, 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 0;
        clr();
        #2;
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_res", bus.result_o, 32'd0);
        chk("rst_pcb", bus.pc_branch_o, 32'd0);
        chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1;
        step();

        // 5 + imm 7
        clr();
        bus.in_valid_i = 1; bus.rf_data0_i = 5; bus.has_imm_i = 1;
        bus.imm32_i = 7; bus.rf_data1_i = 32'hAB; bus.pc_plus1_i = 32'h40;
        bus.ctrl_i = 6'h2A; bus.rf_waddr_i = 5'd9;
        #1;
        chk("rf_dst", 32'(bus.rf_dst_o), 32'd9);
        sc_check("add_imm");
        chk("add_imm_12", bus.result_o, 32'd12);
        bus.in_valid_i = 0;
        step();
        chk("idle_valid", 32'(bus.valid_o), 32'd0);

        // Bypass selection
        clr();
        bus.in_valid_i = 1; bus.src0_sel_i = 2; bus.src1_sel_i = 1;
        bus.byp_data_i = {32'h100, 32'h23};
        sc_check("byp");
        chk("byp_123", bus.result_o, 32'h123);
        bus.src0_sel_i = 3;
        sc_check("byp_sel3");
        chk("byp_sel3_23", bus.result_o, 32'h23);

        // Jumps with pc wrap
        clr();
        bus.in_valid_i = 1; bus.jump_i = 1; bus.has_imm_i = 1;
        bus.pc_plus1_i = 32'hFFFF_FFFF; bus.rf_data0_i = 32'h1000;
        bus.imm32_i = 32'h24;
        sc_check("jalr");
        bus.has_imm_i = 0; bus.imm32_i = 32'h10;
        sc_check("jal_wrap");

        // Hold freezes the output register and blocks acceptance
        clr();
        bus.in_valid_i = 1; bus.rf_data0_i = 32'h11; bus.rf_data1_i = 32'h22;
        sc_check("pre_hold");
        bus.hold_i = 1; bus.rf_data0_i = 32'h500;
        #1;
        chk("hold_ready", 32'(bus.in_ready_o), 32'd0);
        step();
        step();
        chk("hold_valid", 32'(bus.valid_o), 32'd1);
        chk("hold_res", bus.result_o, 32'h33);
        bus.hold_i = 0;
        sc_check("post_hold");

        // Flush with a valid op: nothing accepted
        bus.flush_i = 1;
        step();
        chk("flush_valid", 32'(bus.valid_o), 32'd0);
        bus.flush_i = 0; bus.in_valid_i = 0;
        step();
        chk("flush_noacc", 32'(bus.valid_o), 32'd0);

        // Randomized single-cycle ops
        for (int i = 0; i < 40; i++) begin
            logic [31:0] er, ep, ew;
            bit          ev;
            clr();
            bus.in_valid_i = ($urandom_range(0, 3) != 0);
            bus.alu_op_i = 3'($urandom_range(0, 7));
            bus.alu_alt_i = 1'($urandom);
            bus.has_imm_i = 1'($urandom);
            bus.jump_i = ($urandom_range(0, 5) == 0);
            bus.muldiv_i = (!MD_EN) && ($urandom_range(0, 7) == 0);
            bus.ctrl_i = 6'($urandom); bus.rf_waddr_i = 5'($urandom);
            bus.imm32_i = $urandom; bus.pc_plus1_i = $urandom;
            bus.rf_data0_i = $urandom; bus.rf_data1_i = $urandom;
            bus.byp_data_i = {$urandom, $urandom};
            bus.src0_sel_i = 2'($urandom_range(0, 3));
            bus.src1_sel_i = 2'($urandom_range(0, 3));
            ev = bus.in_valid_i;
            model_sc(er, ep, ew);
            step();
            chk("rnd_valid", 32'(bus.valid_o), 32'(ev));
            if (ev) begin
                chk("rnd_res", bus.result_o, er);
                chk("rnd_pcb", bus.pc_branch_o, ep);
                chk("rnd_wd", bus.mem_wdata_o, ew);
            end
        end

        // Multiply / divide
        run_md("mul", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_md("mulhu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_md("divu", 2'd2, 32'd100, 32'd7, 0, 0);
        run_md("remu", 2'd3, 32'd100, 32'd7, 0, 0);
        run_md("divu0", 2'd2, 32'd9, 32'd0, 0, 0);
        run_md("remu0", 2'd3, 32'd9, 32'd0, 0, 0);
        run_md("divu_hold", 2'd2, 32'd100, 32'd7, 10, 5);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0
               : $urandom >> $urandom_range(0, 31);
            run_md("md_rnd", 2'($urandom_range(0, 3)), ra, rb, 0, 0);
        end

        // Flush mid-multiply
        clr();
        bus.in_valid_i = 1; bus.muldiv_i = 1;
        bus.rf_data0_i = 3; bus.rf_data1_i = 5;
        step();
        clr();
        repeat (9) step();
        chk("fl_mid_busy", 32'(bus.busy_o), 32'(MD_EN));
        bus.flush_i = 1;
        step();
        bus.flush_i = 0;
        chk("fl_mid", {bus.valid_o, bus.busy_o}, 32'd0);
        repeat (30) step();
        chk("fl_mid_quiet", 32'(bus.valid_o), 32'd0);

        // Flush in the completion cycle, with a new op offered
        bus.in_valid_i = 1; bus.muldiv_i = 1;
        bus.rf_data0_i = 6; bus.rf_data1_i = 7;
        step();
        clr();
        repeat (31) step();
        bus.flush_i = 1; bus.in_valid_i = 1;
        step();
        chk("fl_end", {bus.valid_o, bus.busy_o}, 32'd0);
        clr();
        step();
        chk("fl_end_quiet", 32'(bus.valid_o), 32'd0);

        // Asynchronous reset while busy / streaming
        clr();
        bus.in_valid_i = 1; bus.muldiv_i = 1;
        bus.rf_data0_i = 3; bus.rf_data1_i = 5;
        step();
        bus.muldiv_i = 0; bus.rf_data0_i = 32'h77; bus.imm32_i = 32'h99;
        bus.pc_plus1_i = 32'h1234;
        repeat (3) step();
        #1;
        rst_n = 0;
        #1;
        chk("arst_vb", {bus.valid_o, bus.busy_o}, 32'd0);
        chk("arst_res", bus.result_o, 32'd0);
        chk("arst_pcb", bus.pc_branch_o, 32'd0);
        @(negedge clk);
        rst_n = 1;
        sc_check("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
